// File: rtl/fuzzy_pkg.sv
// Shared types and helpers for the binarize loader and the 3x3 pooling stage.
// Provides the loader state enum, default frame geometry and the bit-index helper.
// No logic; nothing here has latency or backpressure.
package fuzzy_pkg;

    localparam int ROW_LIMIT_DEF = 10;
    localparam int PIX_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

    // Flat-vector position of pixel (r, c) in a row_limit x row_limit frame.
    function automatic int idx(input int r, input int c, input int row_limit = ROW_LIMIT_DEF);
        return r * row_limit + c;
    endfunction

endpackage

// File: rtl/pix_binarizer.sv
// Thresholds one grayscale pixel to a single bit against a per-frame latched threshold.
// Latency: combinational compare; the threshold register updates on the load edge.
// Backpressure: none; the caller qualifies i_load with the accepted handshake.
//
// Ports: i_load marks an accepted SOF beat; i_threshold is captured on it and also
// used for that same beat, so pixel (0,0) is compared against the new threshold.
module pix_binarizer #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [PIX_W-1:0] i_threshold,
    input  logic [PIX_W-1:0] i_pix,
    output logic             o_bit
);

    logic [PIX_W-1:0] r_thr;
    logic [PIX_W-1:0] w_thr;

    assign w_thr = i_load ? i_threshold : r_thr;
    assign o_bit = (i_pix >= w_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr <= '0;
        end else if (i_load) begin
            r_thr <= i_threshold;
        end
    end

endmodule

// File: rtl/binarize_frame_loader.sv
// Binarizes a raster pixel stream into a Row_Limit x Row_Limit bit frame for the pooling stage.
// Latency: last pixel accepted at edge N, frame_valid and frame_cnt update after edge N.
// Backpressure: pix_ready drops while a finished frame waits for frame_ack (ping-pong: only when both buffers are full).
//
// Ports: pix_valid/pix_ready/pix_sof/pix_data/threshold form the input stream;
// frame_valid/frame_data/frame_ack the output handshake; sof_err pulses on a
// mid-frame SOF; frame_cnt counts completed frames and wraps.
// Build option: LOADER_PINGPONG_EN selects two frame buffers so filling continues during HOLD.
module binarize_frame_loader
    import fuzzy_pkg::*;
#(
    parameter int Row_Limit = ROW_LIMIT_DEF,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic                           pix_sof,
    input  logic [PIX_W-1:0]               pix_data,
    input  logic [PIX_W-1:0]               threshold,
    output logic                           frame_valid,
    output logic [Row_Limit*Row_Limit-1:0] frame_data,
    input  logic                           frame_ack,
    output logic                           sof_err,
    output logic [CNT_W-1:0]               frame_cnt
);

    localparam int NN    = Row_Limit * Row_Limit;
    localparam int POS_W = (Row_Limit > 1) ? $clog2(Row_Limit) : 1;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(Row_Limit - 1);

    loader_state_t    r_state, w_next;
    logic             r_rdy_en;
    logic [POS_W-1:0] r_row, r_col;
    logic             r_sof_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_acc, w_sof_beat, w_fill_beat, w_last, w_done, w_bit;
    logic [IDX_W-1:0] w_idx;

    // r_rdy_en keeps pix_ready low through reset and raises it on the first edge after release.
    assign pix_ready   = r_rdy_en & (r_state != HOLD);
    assign w_acc       = pix_valid & pix_ready;
    assign w_sof_beat  = w_acc & pix_sof;
    assign w_fill_beat = w_acc & ~pix_sof & (r_state == FILL);
    assign w_last      = (r_row == LAST_POS) && (r_col == LAST_POS);
    assign w_done      = w_fill_beat & w_last;
    assign w_idx       = IDX_W'(idx(int'(r_row), int'(r_col), Row_Limit));
    assign sof_err     = r_sof_err;
    assign frame_cnt   = r_cnt;

    pix_binarizer #(.PIX_W(PIX_W)) u_bin (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_sof_beat),
        .i_threshold (threshold),
        .i_pix       (pix_data),
        .o_bit       (w_bit)
    );

`ifdef LOADER_PINGPONG_EN
    // HOLD here means the fill buffer is complete but the output buffer is still unacked.
    logic [NN-1:0] r_buf [2];
    logic          r_fill_sel, r_out_sel, r_frame_valid;
    logic          w_out_free, w_promote;

    assign w_out_free  = ~r_frame_valid | frame_ack;
    assign w_promote   = (w_done & w_out_free) | ((r_state == HOLD) & frame_ack);
    assign frame_valid = r_frame_valid;
    assign frame_data  = r_buf[r_out_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0]      <= '0;
            r_buf[1]      <= '0;
            r_fill_sel    <= 1'b0;
            r_out_sel     <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            if (w_sof_beat) begin
                r_buf[r_fill_sel] <= NN'(w_bit);
            end else if (w_fill_beat) begin
                r_buf[r_fill_sel][w_idx] <= w_bit;
            end
            // Swap roles: the just-completed fill buffer becomes the output.
            if (w_promote) begin
                r_out_sel     <= r_fill_sel;
                r_fill_sel    <= ~r_fill_sel;
                r_frame_valid <= 1'b1;
            end else if (frame_ack) begin
                r_frame_valid <= 1'b0;
            end
        end
    end
`else
    logic [NN-1:0] r_buf;

    assign frame_valid = (r_state == HOLD);
    assign frame_data  = r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (w_sof_beat) begin
            r_buf <= NN'(w_bit);
        end else if (w_fill_beat) begin
            r_buf[w_idx] <= w_bit;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_sof_beat) w_next = FILL;
            FILL: begin
                if (w_done) begin
`ifdef LOADER_PINGPONG_EN
                    w_next = w_out_free ? IDLE : HOLD;
`else
                    w_next = HOLD;
`endif
                end
            end
            HOLD: if (frame_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rdy_en  <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_sof_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_rdy_en  <= 1'b1;
            // A SOF while filling restarts the frame; in IDLE it is a normal start.
            r_sof_err <= w_sof_beat & (r_state == FILL);
            if (w_sof_beat) begin
                r_row <= '0;
                r_col <= POS_W'(1);
            end else if (w_fill_beat) begin
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == LAST_POS) begin
                    r_col <= '0;
                    r_row <= r_row + POS_W'(1);
                end else begin
                    r_col <= r_col + POS_W'(1);
                end
            end
            if (w_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
